// File: rtl/tt_uart_pkg.sv
// Shared constants for the UART transmitter: FSM state encodings, frame bit counts, output-enable value.
// The frame length depends on the build macro UART_TX_PARITY_EN.
package tt_uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: power-of-two depth, pointers carry an extra MSB so full and empty
// are distinguishable; full/empty/count are combinational from the pointers.
module uart_tx_fifo
    import tt_uart_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_BITS,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push while full is still accepted when a pop frees the head slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/tt_um_uart_tx.sv
// Buffered UART transmitter tile: synchronised write strobe feeds a FIFO drained by a 8N1 framer.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module tt_um_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

    logic        wr_s1, wr_s2, wr_d;
    logic        push, pop;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count;
    logic [7:0]  fifo_rdata;
    logic        overflow;
    state_t      state;
    logic [15:0] baud;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        tx;
    logic        busy;
    logic [4:0]  count_w;
    logic [3:0]  count_out;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:1]};

    // Two-flop synchroniser followed by a rising-edge detector on the write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_s1 <= 1'b0;
            wr_s2 <= 1'b0;
            wr_d  <= 1'b0;
        end else begin
            wr_s1 <= uio_in[0];
            wr_s2 <= wr_s1;
            wr_d  <= wr_s2;
        end
    end

    assign push = wr_s2 && !wr_d;
    assign pop  = (state == ST_IDLE) && !fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DATA_W(8),
        .AW    (AW)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .wdata(ui_in),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else if (push && fifo_full && !pop) overflow <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= ST_START;
                        baud  <= BAUD_RELOAD;
                    end
                end
                ST_START: begin
                    if (baud == 16'd0) begin
                        state   <= ST_DATA;
                        baud    <= BAUD_RELOAD;
                        bit_idx <= '0;
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud == 16'd0) begin
                        baud <= BAUD_RELOAD;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud == 16'd0) begin
                        state <= ST_STOP;
                        baud  <= BAUD_RELOAD;
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud == 16'd0) state <= ST_IDLE;
                    else               baud  <= baud - 16'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data path: byte loaded on pop, shifted LSB-first at each data bit boundary.
    always_ff @(posedge clk) begin
        if (pop)                                    shift <= fifo_rdata;
        else if (state == ST_DATA && baud == 16'd0) shift <= {1'b0, shift[7:1]};
    end

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    always_ff @(posedge clk) begin
        if (pop) parity_bit <= even_parity(fifo_rdata);
    end
`endif

    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = parity_bit;
`endif
            default:   tx = 1'b1;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // The 4-bit occupancy field saturates for the 16-deep build where count can reach 16.
    assign count_w   = 5'(fifo_count);
    assign count_out = (count_w > 5'd15) ? 4'hF : count_w[3:0];

    assign uo_out  = {3'b000, overflow, fifo_empty, fifo_full, busy, tx};
    assign uio_out = {count_out, 4'b0000};
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// Directed bench for tt_um_uart_tx (CLK_DIV=4, FIFO_DEPTH=4); expectations follow UART_TX_PARITY_EN.
module tb_tt_um_uart_tx;
    import tt_uart_pkg::*;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_pass   = 0;

    tt_um_uart_tx #(
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        ui_in  = d;
        uio_in = 8'h01;
        @(negedge clk);
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    task automatic wait_tx_low(input string tag);
        int n = 0;
        while (uo_out[0] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, 32'(n < 400), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (uo_out[1] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_seen"}, 32'(n < 400), 32'd1);
    endtask

    // Expects START, 8 data bits LSB first, optional even parity, STOP; each DIV cycles, busy throughout.
    task automatic rx_frame(input logic [7:0] b, input string tag);
        logic [FRAME_BITS-1:0] bits;
        logic [3:0] txs;
        logic [3:0] bsy;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        bits[FRAME_BITS-1] = 1'b1;
        wait_tx_low(tag);
        for (int k = 0; k < FRAME_BITS; k++) begin
            for (int j = 0; j < DIV; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                txs[j] = uo_out[0];
                bsy[j] = uo_out[1];
            end
            check($sformatf("%s_bit%0d", tag, k), {24'd0, bsy, txs}, {24'd0, 4'hF, {4{bits[k]}}});
        end
        @(negedge clk);
        check({tag, "_idle_after"}, {30'd0, uo_out[1:0]}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        // Reset state
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_uo_out", {24'd0, uo_out}, 32'h09);
        check("reset_uio_out", {24'd0, uio_out}, 32'h00);
        check("reset_uio_oe", {24'd0, uio_oe}, 32'hF0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame
        push_byte(8'hA5);
        rx_frame(8'hA5, "a5");
        check("a5_done_uo_out", {24'd0, uo_out}, 32'h09);

        // Fill FIFO behind a frame in flight, then overflow
        push_byte(8'h55);
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        push_byte(8'h04);
        @(negedge clk);
        check("fill_count", {24'd0, uio_out}, 32'h40);
        check("fill_flags", {28'd0, uo_out[4:1]}, 32'b0011);
        push_byte(8'h05);
        @(negedge clk);
        check("ovf_flags", {28'd0, uo_out[4:1]}, 32'b1011);
        check("ovf_count", {24'd0, uio_out}, 32'h40);
        wait_idle("ovf");
        rx_frame(8'h01, "q01");
        rx_frame(8'h02, "q02");
        rx_frame(8'h03, "q03");
        rx_frame(8'h04, "q04");
        check("drain_uo_out", {24'd0, uo_out}, 32'h19);
        check("drain_uio_out", {24'd0, uio_out}, 32'h00);

        // Reset clears sticky overflow
        rst_n = 1'b0;
        @(negedge clk);
        check("ovf_clear_uo_out", {24'd0, uo_out}, 32'h09);
        rst_n = 1'b1;

        // Strobe held high enqueues once
        push_byte(8'h3C);
        @(negedge clk);
        ui_in  = 8'hC3;
        uio_in = 8'h01;
        repeat (20) @(negedge clk);
        uio_in = 8'h00;
        repeat (4) @(negedge clk);
        check("hold_count", {24'd0, uio_out}, 32'h10);
        wait_idle("hold");
        rx_frame(8'hC3, "hold");
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (uo_out[1] !== 1'b0) bad++;
        end
        check("hold_no_extra", 32'(bad), 32'd0);
        check("hold_count_end", {24'd0, uio_out}, 32'h00);

        // Asynchronous reset mid-DATA
        push_byte(8'hA5);
        wait_tx_low("rst");
        push_byte(8'h5A);
        repeat (4) @(negedge clk);
        check("rst_pre_count", {24'd0, uio_out}, 32'h10);
        check("rst_pre_busy", {31'd0, uo_out[1]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_uo_out", {24'd0, uo_out}, 32'h09);
        check("rst_async_uio_out", {24'd0, uio_out}, 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (uo_out[0] !== 1'b1 || uo_out[1] !== 1'b0) bad++;
        end
        check("rst_no_resume", 32'(bad), 32'd0);

        // Odd-weight byte exercises the parity bit in the parity build
        push_byte(8'h07);
        rx_frame(8'h07, "b07");
        check("b07_done_uo_out", {24'd0, uo_out}, 32'h09);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tt_um_uart_tx.md
TT_UM_UART_TX -- requirements
Module: tt_um_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, giving clock cycles per UART bit period (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving transmit FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, the single design clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ena, input, 1, the tile-selected indicator; ignored by the design.
REQ-006 SHALL have port ui_in, input, 8, the data byte to enqueue.
REQ-007 SHALL have port uio_in, input, 8; bit 0 is the write strobe (wr); bits 7:1 are ignored.
REQ-008 SHALL have port uo_out, output, 8: [0] tx, [1] busy, [2] full, [3] empty, [4] overflow (sticky), [7:5] = 0.
REQ-009 SHALL have port uio_out, output, 8: [7:4] FIFO occupancy count, [3:0] = 0.
REQ-010 SHALL have port uio_oe, output, 8, constant 8'hF0.

Function
REQ-011 SHALL synchronise wr through a two-flop synchroniser, then detect rising edges; each detected edge is one push request.
REQ-012 SHALL, on a push request with FIFO not full, write ui_in as sampled in the detection cycle; occupancy increments next cycle.
REQ-013 SHALL, on a push request with FIFO full and no pop in the same cycle, drop the byte and set overflow; overflow clears only on reset.
REQ-014 SHALL, on a simultaneous push and pop, accept the push (including when full) and leave the count unchanged.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL, in IDLE with FIFO non-empty, pop the head byte into a shift register and enter START next cycle.
REQ-017 SHALL hold each of START (tx=0), each DATA bit (LSB first), PARITY, and STOP (tx=1) for exactly CLK_DIV cycles, counted by a baud counter reloaded on every state or bit change.
REQ-018 SHALL go from DATA to PARITY (when enabled) or STOP after the 8th bit, and from STOP to IDLE; IDLE lasts at least one cycle between frames.
REQ-019 SHALL drive tx=1 in IDLE; busy=1 in every state except IDLE.
REQ-020 SHALL derive full, empty and count combinationally from the FIFO pointers; pointer wrap-around SHALL use an extra MSB to distinguish full from empty.

Reset
REQ-021 SHALL, while rst_n=0, force immediately: FSM=IDLE, tx=1, busy=0, FIFO empty (count=0, empty=1, full=0), overflow=0, synchroniser and edge-detect flops=0.
REQ-022 SHALL abort a frame in progress on reset; no partial frame SHALL resume after release.

Configuration
REQ-023 SHALL, with macro UART_TX_PARITY_EN defined, transmit an even-parity bit over the 8 data bits in PARITY; frame = 11 bit periods.
REQ-024 SHALL, without UART_TX_PARITY_EN, never enter PARITY; frame = 10 bit periods; no parity logic SHALL be synthesised.

Structure
REQ-025 SHALL place the FSM state enum, frame bit-count constants and the uio_oe constant in shared package tt_uart_pkg.
REQ-026 SHALL implement the FIFO as sub-module uart_tx_fifo (push/pop/data/full/empty/count), instantiated once.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-027 SHALL check: reset held 5 cycles -> uo_out=8'h09 (tx=1, empty=1), uio_out=0, uio_oe=8'hF0.
REQ-028 SHALL check: push 8'hA5 -> tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles; busy high for the 40-cycle frame (44 with parity, parity bit 0).
REQ-029 SHALL check: 5 pushes 8'h01..8'h05 while busy -> count reaches 4, full=1, 5th byte accepted only if a pop coincides, else overflow=1; the bytes transmitted match the accepted bytes in order.
REQ-030 SHALL check: wr held high 20 cycles -> exactly one byte enqueued.
REQ-031 SHALL check: rst_n pulsed low mid-DATA -> tx=1, busy=0, count=0 asynchronously; no further frame bits appear.
REQ-032 SHALL check: push 8'h07 with UART_TX_PARITY_EN -> parity bit 1; frame is 44 cycles.
